// File: rtl/rcvr_ctrl_pkg.sv
// Shared types and defaults for the receiver-word stream controller.
package rcvr_ctrl_pkg;

  localparam int WORD_W_DEF = 10;
  localparam int CNT_W_DEF  = 4;

  // Binary-encoded controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Hit-map bit position for the idx-th shifted bit. The map is MSB-first,
  // matching the order in which the word leaves the shifter.
  function automatic int unsigned hit_pos(input int unsigned idx,
                                          input int unsigned word_w = WORD_W_DEF);
    return word_w - 1 - idx;
  endfunction

endpackage

// File: rtl/rcvr_shifter.sv
// Loadable left shift register; the MSB is the serial output.
module rcvr_shifter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  output logic         msb_o
);

  logic [W-1:0] data_q;

  // Clear has priority over load, load over shift.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = data_q[W-1];

endmodule

// File: rtl/rcvr_stream_ctrl.sv
// Sequencer feeding a serial pattern detector from parallel receiver words:
// accept a word, clear the detector for one cycle, shift the word out MSB-first
// while sampling the detector output, then publish hit count/map with a done pulse.
module rcvr_stream_ctrl
  import rcvr_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              r,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_word,
  output logic              det_clr,
  output logic              ser_bit,
  output logic              ser_en,
  input  logic              activate,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  hit_count,
  output logic [WORD_W-1:0] hit_map
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic [WORD_W-1:0]   hit_map_q, hit_map_d;
  logic                aborted_q, aborted_d;

  logic accept;
  logic last_bit;
  logic shift_en;

  // Reset masks load_ready so no word is taken in the reset cycle itself.
  assign load_ready = !r && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept     = load_valid && load_ready;
  assign last_bit   = (idx_q == CNT_W'(WORD_W - 1));
  // An aborting cycle leaves the remaining bits unshifted.
  assign shift_en   = (state_q == ST_SHIFT) && !abort;

  rcvr_shifter #(.W(WORD_W)) u_shifter (
    .clk         (clk),
    .clr_i       (r),
    .load_i      (accept),
    .load_data_i (load_word),
    .shift_i     (shift_en),
    .msb_o       (ser_bit)
  );

  // Next-state, bit index and result accumulation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    hit_count_d = hit_count_q;
    hit_map_d   = hit_map_q;
    aborted_d   = aborted_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d     = ST_CLEAR;
          hit_count_d = '0;
          hit_map_d   = '0;
          aborted_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
        idx_d   = '0;
      end
      ST_SHIFT: begin
        if (activate) begin
          hit_count_d = hit_count_q + CNT_W'(1);
          hit_map_d   = hit_map_q | (WORD_W'(1) << hit_pos(int'(idx_q), WORD_W));
        end
        idx_d = idx_q + CNT_W'(1);
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (r) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      hit_count_q <= '0;
      hit_map_q   <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_count_q <= hit_count_d;
      hit_map_q   <= hit_map_d;
      aborted_q   <= aborted_d;
    end
  end

  assign det_clr   = r || (state_q == ST_CLEAR);
  assign ser_en    = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;
  assign hit_count = hit_count_q;
  assign hit_map   = hit_map_q;

endmodule
